// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor:
// the controller state encoding, decimal constants and a nibble validity check.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        FIN  = 2'd2
    } bcd_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    function automatic logic is_bcd(input logic [3:0] nibble);
        return (nibble <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// Single decimal digit adder: optional nine's complement of b4, binary add with
// carry-in, then +6 correction when the binary sum leaves the 0..9 range.
module bcd_digit_slice
    import bcd_pkg::*;
(
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] s4,
    output logic       co
);

    logic [3:0] bd;
    logic [4:0] t;

    // Five bits are enough even for out-of-range nibbles (15 + 15 + 1 = 31).
    always_comb begin
        bd = sub ? (BCD_MAX - b4) : b4;
        t  = {1'b0, a4} + {1'b0, bd} + {4'b0000, cin};
        if (t > {1'b0, BCD_MAX}) begin
            s4 = t[3:0] + BCD_ADJ;
            co = 1'b1;
        end else begin
            s4 = t[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Digit-serial multi-digit BCD adder/subtractor: latches operands on start,
// resolves one digit per clock LSD first through a single shared digit slice.
module bcd_seq_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    bcd_state_e          state;
    logic [4*DIGITS-1:0] a_lat;
    logic [4*DIGITS-1:0] b_lat;
    logic [4*DIGITS-1:0] res;
    logic [4*DIGITS-1:0] next_res;
    logic                sub_lat;
    logic                carry;
    logic                err_pend;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W+1:0]    bit_pos;
    logic                ops_ok;
    logic [3:0]          slice_s;
    logic                slice_co;

    always_comb begin
        ops_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_bcd(a[4*i +: 4]) || !is_bcd(b[4*i +: 4])) begin
                ops_ok = 1'b0;
            end
        end
    end

    assign bit_pos = {idx, 2'b00};

    bcd_digit_slice u_slice (
        .a4  (a_lat[bit_pos +: 4]),
        .b4  (b_lat[bit_pos +: 4]),
        .cin (carry),
        .sub (sub_lat),
        .s4  (slice_s),
        .co  (slice_co)
    );

    // The final digit is merged here so sum can load on the same edge it is computed.
    always_comb begin
        next_res               = res;
        next_res[bit_pos +: 4] = slice_s;
    end

    // An invalid operand still spends one cycle in ADD so done lands at the same
    // offset as a one-digit operation; no digits are written on that path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_lat    <= '0;
            b_lat    <= '0;
            res      <= '0;
            sub_lat  <= 1'b0;
            carry    <= 1'b0;
            err_pend <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat    <= a;
                        b_lat    <= b;
                        sub_lat  <= sub;
                        carry    <= sub ? 1'b1 : cin;
                        err_pend <= !ops_ok;
                        idx      <= '0;
                        res      <= '0;
                        busy     <= 1'b1;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    if (err_pend) begin
                        sum   <= '0;
                        cout  <= 1'b0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        res   <= next_res;
                        carry <= slice_co;
                        if (idx == LAST_IDX) begin
                            sum   <= next_res;
                            cout  <= slice_co;
                            err   <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FIN: begin
                    busy     <= 1'b0;
                    idx      <= '0;
                    err_pend <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_adder.sv
// Self-checking bench for bcd_seq_adder: DIGITS=4, 1 and 8 instances share the
// operand bus; a decimal reference model feeds a scoreboard popped on done.
module tb_bcd_seq_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        sub_i;
    logic        cin_i;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    int          sel;

    logic [15:0] sum4;
    logic [3:0]  sum1;
    logic [31:0] sum8;
    logic        cout4, cout1, cout8;
    logic        err4, err1, err8;
    logic        busy4, busy1, busy8;
    logic        done4, done1, done8;

    logic [63:0] cur_sum;
    logic        cur_cout, cur_err, cur_busy, cur_done;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   start_cyc    = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_seq_adder #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start_i && sel == 4), .sub(sub_i), .cin(cin_i),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .sum(sum4), .cout(cout4), .err(err4),
        .busy(busy4), .done(done4)
    );

    bcd_seq_adder #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_i && sel == 1), .sub(sub_i), .cin(cin_i),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .sum(sum1), .cout(cout1), .err(err1),
        .busy(busy1), .done(done1)
    );

    bcd_seq_adder #(.DIGITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_i && sel == 8), .sub(sub_i), .cin(cin_i),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .sum(sum8), .cout(cout8), .err(err8),
        .busy(busy8), .done(done8)
    );

    always_comb begin
        cur_sum  = {48'd0, sum4};
        cur_cout = cout4;
        cur_err  = err4;
        cur_busy = busy4;
        cur_done = done4;
        if (sel == 1) begin
            cur_sum  = {60'd0, sum1};
            cur_cout = cout1;
            cur_err  = err1;
            cur_busy = busy1;
            cur_done = done1;
        end else if (sel == 8) begin
            cur_sum  = {32'd0, sum8};
            cur_cout = cout8;
            cur_err  = err8;
            cur_busy = busy8;
            cur_done = done8;
        end
    end

    function automatic longint bcd2int(input logic [63:0] v, input int d);
        longint r = 0;
        for (int i = d - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] int2bcd(input longint v, input int d);
        logic [63:0] r = '0;
        longint      x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input int d, input logic s, input logic c,
                                   input logic [63:0] av, input logic [63:0] bv);
        exp_t   e;
        logic   bad = 1'b0;
        longint p   = 1;
        longint r;
        for (int i = 0; i < d; i++) begin
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) bad = 1'b1;
            p = p * 10;
        end
        if (bad) begin
            e.sum = '0; e.cout = 1'b0; e.err = 1'b1; e.lat = 1;
        end else begin
            if (s) r = bcd2int(av, d) + (p - 1 - bcd2int(bv, d)) + 1;
            else   r = bcd2int(av, d) + bcd2int(bv, d) + longint'(c);
            e.sum = int2bcd(r % p, d); e.cout = (r >= p); e.err = 1'b0; e.lat = d;
        end
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic s, input logic c,
                                 input logic [63:0] av, input logic [63:0] bv);
        @(negedge clk);
        sel = d; sub_i = s; cin_i = c; a_bus = av; b_bus = bv; start_i = 1'b1;
        sb.push_back(model(d, s, c, av, bv));
        @(posedge clk); #1;
        start_cyc = cyc;
        start_i   = 1'b0;
        checkOutput("busy_after_start", {63'd0, cur_busy}, 64'd1);
    endtask

    task automatic waitResult(input string tag);
        exp_t e;
        int   n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!cur_done && n < 40);
        if (sb.size() == 0) begin
            checkOutput({tag, "_scoreboard"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, "_done"}, {63'd0, cur_done}, 64'd1);
            checkOutput({tag, "_lat"}, 64'(cyc - start_cyc), 64'(e.lat));
            checkOutput({tag, "_sum"}, cur_sum, e.sum);
            checkOutput({tag, "_cout"}, {63'd0, cur_cout}, {63'd0, e.cout});
            checkOutput({tag, "_err"}, {63'd0, cur_err}, {63'd0, e.err});
        end
    endtask

    task automatic finishOp(input string tag);
        @(posedge clk); #1;
        checkOutput({tag, "_done_fall"}, {63'd0, cur_done}, 64'd0);
        checkOutput({tag, "_busy_fall"}, {63'd0, cur_busy}, 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        int          seen;

        rst = 1'b1; start_i = 1'b0; sub_i = 1'b0; cin_i = 1'b0;
        a_bus = '0; b_bus = '0; sel = 4;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        checkOutput("reset_sum", cur_sum, 64'd0);
        checkOutput("reset_flags", {60'd0, cur_cout, cur_err, cur_busy, cur_done}, 64'd0);

        applyStimulus(4, 1'b0, 1'b0, 64'h1234, 64'h8766); waitResult("add_carry");  finishOp("add_carry");
        applyStimulus(4, 1'b0, 1'b1, 64'h9999, 64'h0000); waitResult("cin_ripple"); finishOp("cin_ripple");
        applyStimulus(4, 1'b0, 1'b0, 64'h0045, 64'h0055); waitResult("add_0100");   finishOp("add_0100");
        applyStimulus(4, 1'b1, 1'b0, 64'h5000, 64'h1234); waitResult("sub_pos");    finishOp("sub_pos");
        applyStimulus(4, 1'b1, 1'b0, 64'h1234, 64'h5000); waitResult("sub_neg");    finishOp("sub_neg");
        applyStimulus(4, 1'b1, 1'b1, 64'h0000, 64'h0000); waitResult("sub_zero");   finishOp("sub_zero");
        applyStimulus(4, 1'b0, 1'b0, 64'h12A4, 64'h0001); waitResult("invalid");    finishOp("invalid");
        applyStimulus(4, 1'b0, 1'b0, 64'h0001, 64'h0001); waitResult("err_clear");  finishOp("err_clear");

        // start pulsed and operands disturbed mid-ADD, then start on the FIN cycle
        applyStimulus(4, 1'b0, 1'b0, 64'h0123, 64'h0456);
        @(negedge clk); a_bus = 64'h9999; b_bus = 64'h9999; sub_i = 1'b1; start_i = 1'b1;
        @(negedge clk); start_i = 1'b0;
        waitResult("mid_add");
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1;
        checkOutput("fin_start_busy", {63'd0, cur_busy}, 64'd0);
        @(negedge clk); start_i = 1'b0;
        @(posedge clk); #1;
        checkOutput("fin_start_idle", {62'd0, cur_busy, cur_done}, 64'd0);
        checkOutput("fin_start_sum", cur_sum, 64'h0579);
        sub_i = 1'b0;

        // start held high: second op accepted DIGITS+2 cycles after the first
        @(negedge clk);
        a_bus = 64'h0001; b_bus = 64'h0002; cin_i = 1'b0; start_i = 1'b1;
        sb.push_back(model(4, 1'b0, 1'b0, 64'h0001, 64'h0002));
        sb.push_back(model(4, 1'b0, 1'b0, 64'h0001, 64'h0002));
        @(posedge clk); #1;
        start_cyc = cyc;
        waitResult("held1");
        start_cyc = cyc + 2;
        waitResult("held2");
        @(negedge clk); start_i = 1'b0;
        finishOp("held2");

        // asynchronous reset during the digit-2 cycle
        applyStimulus(4, 1'b0, 1'b0, 64'h1111, 64'h2222);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1; #1;
        checkOutput("rst_sum", cur_sum, 64'd0);
        checkOutput("rst_flags", {60'd0, cur_cout, cur_err, cur_busy, cur_done}, 64'd0);
        void'(sb.pop_front());
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (cur_done) seen++;
        end
        checkOutput("rst_no_done", 64'(seen), 64'd0);
        applyStimulus(4, 1'b0, 1'b0, 64'h0001, 64'h0002); waitResult("post_rst"); finishOp("post_rst");

        applyStimulus(1, 1'b0, 1'b0, 64'h9, 64'h1); waitResult("d1_add"); finishOp("d1_add");
        applyStimulus(1, 1'b1, 1'b0, 64'h3, 64'h7); waitResult("d1_sub"); finishOp("d1_sub");

        for (int k = 0; k < 6; k++) begin
            ra = '0; rb = '0;
            for (int i = 0; i < 8; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            applyStimulus(8, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, rb);
            waitResult("d8_rand");
            finishOp("d8_rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_seq_adder.md
# bcd_seq_adder

Digit-serial, parametrised multi-digit BCD adder/subtractor. It latches two packed BCD operands on a start strobe and processes one decimal digit per clock, least-significant digit first, using a single combinational digit-adder slice. It returns a registered packed BCD result, a decimal carry/no-borrow flag and an error flag. It is the multi-digit, sequential successor to the team's single-digit combinational BCD adder, for use in calculator/counter datapaths where area matters more than latency.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Legal range 1..16.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request; sampled only when `busy`=0.
- `sub` input 1: 0 = A+B+`cin`; 1 = A−B (ten's complement), `cin` ignored.
- `cin` input 1: decimal carry-in for add mode.
- `a` input 4·DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- `b` input 4·DIGITS: operand B, same packing.
- `sum` output 4·DIGITS: registered result, packed BCD.
- `cout` output 1: add mode = decimal carry out; sub mode = 1 if A≥B (no borrow).
- `err` output 1: 1 if any latched operand nibble exceeded 9.
- `busy` output 1: 1 from the cycle after `start` is accepted until `done` falls.
- `done` output 1: one-cycle pulse; `sum`/`cout`/`err` valid from this cycle on.

## Operation
- States: IDLE, ADD, FIN.
- IDLE: `busy`=0. On `start`=1:
  - Latch `a`, `b` and `sub`.
  - Digit index := 0.
  - Carry := `sub` ? 1 : `cin`.
  - Check every nibble of `a` and `b` for a value >9. If any is invalid, go to FIN with err pending. Otherwise go to ADD.
- ADD, one digit per cycle:
  - bd = `sub` ? 9−b[i] : b[i].
  - t = a[i] + bd + carry, computed 5 bits wide.
  - If t>9: digit = (t+6)[3:0] and carry = 1. Otherwise digit = t[3:0] and carry = 0.
  - Write the digit into result-shift register position i.
  - After index DIGITS−1, go to FIN.
- FIN, one cycle:
  - `done`=1.
  - `sum`, `cout` and `err` are loaded at FIN entry. In the err case, `sum`=0, `cout`=0 and `err`=1.
  - Return to IDLE.
- Outputs hold their values until the next FIN. A new `start` does not clear them early.
- Sub mode with A<B: `sum` = 10^DIGITS − (B−A) and `cout`=0.
- `start` while `busy`=1 is ignored; no queuing.
- `start` on the FIN cycle is ignored (`busy`=1). The earliest accepted `start` is in the first IDLE cycle after FIN.
- Input changes after acceptance have no effect, because operands are latched.
- Reset values: `sum`=0, `cout`=0, `err`=0, `busy`=0, `done`=0, state=IDLE, carry=0, index=0.
- Reset mid-operation aborts immediately, with no `done` pulse.

## Timing
- `start` sampled at edge k, valid operands: ADD digits are computed at edges k+1 … k+DIGITS. `done`=1 between edges k+DIGITS and k+DIGITS+1.
- `busy`=1 between edges k and k+DIGITS+1.
- Error case: `done` pulses between edges k+1 and k+2.
- Throughput: one operation per DIGITS+2 cycles when `start` is held high.
- Index counter width: clog2(DIGITS), minimum 1 bit.
- Carry and t are internal only; there are no combinational paths from inputs to outputs.

## Structure
- Package `bcd_pkg` holds:
  - the state enum (IDLE, ADD, FIN);
  - the constants BCD_MAX=9 and BCD_ADJ=6;
  - a function `is_bcd(nibble)`.
- Sub-module `bcd_digit_slice` is combinational: inputs (a4, b4, cin, sub), outputs (s4, co). It contains the 9's-complement mux and the +6 correction. It is instantiated once.
- The top level contains the FSM, operand shift/index registers, result register and error check.

## Test plan
All cases use DIGITS=4.
- Add with carry out: `a`=1234, `b`=8766, `cin`=0, `start` at edge 0 → `sum`=0000, `cout`=1, `err`=0. `done` high between edges 4 and 5; `busy` high between edges 0 and 5.
- Carry-in ripple: `a`=9999, `b`=0000, `cin`=1 → `sum`=0000, `cout`=1. Also `a`=0045, `b`=0055, `cin`=0 → `sum`=0100, `cout`=0.
- Subtraction:
  - `sub`=1, 5000−1234 → `sum`=3766, `cout`=1.
  - `sub`=1, 1234−5000 → `sum`=6234, `cout`=0.
  - `sub`=1, 0000−0000 with `cin`=1 → `sum`=0000, `cout`=1 (`cin` ignored).
- Invalid input: `a`=0x12A4, `b`=0001 → `done` between edges 1 and 2, `err`=1, `sum`=0000, `cout`=0. The next valid op 0001+0001 clears `err` and gives `sum`=0002.
- Protocol:
  - `start` held high continuously → an accepted op every 6 cycles.
  - `start` pulsed mid-ADD and on the FIN cycle → ignored, result unchanged.
  - `a`/`b` changed during ADD → no effect on the result.
- Reset: assert `rst` asynchronously at the digit-2 cycle → all outputs 0 and `busy`=0 immediately, no `done`. A following 0001+0002 returns 0003 with normal timing.
- Parameter sweep: DIGITS=1 (9+1 → 0, `cout`=1) and DIGITS=8 with random valid operands checked against a decimal reference model.
